// File: rtl/pipeline_pkg.sv
// Shared pipeline types: inter-stage payload structs, their widths, and the
// skid-stage state encoding used by pipe_skid_stage.
package pipeline_pkg;

  // IF/ID payload: fetched instruction and its PC.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } IFID_Pipe_t;

  // ID/EX payload: operands, immediate and decoded control.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [3:0]  alu_op;
    logic        mem_rd;
    logic        mem_wr;
    logic        reg_wr;
  } IDEX_Pipe_t;

  // EX/MEM payload: ALU result, store data and write-back control.
  typedef struct packed {
    logic [31:0] alu_res;
    logic [31:0] store_val;
    logic [4:0]  rd;
    logic        mem_rd;
    logic        mem_wr;
    logic        reg_wr;
  } EXMEM_Pipe_t;

  // Widths for instantiating pipe_skid_stage with DATA_W matching a struct.
  localparam int unsigned IFID_W  = $bits(IFID_Pipe_t);
  localparam int unsigned IDEX_W  = $bits(IDEX_Pipe_t);
  localparam int unsigned EXMEM_W = $bits(EXMEM_Pipe_t);

  // Skid-stage occupancy state; the encoding equals the number of held beats.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

  // Number of beats held in a given state.
  function automatic logic [1:0] skid_occupancy(input skid_state_e s);
    logic [1:0] occ;
    occ = 2'd0;
    case (s)
      EMPTY:   occ = 2'd0;
      BUSY:    occ = 2'd1;
      FULL:    occ = 2'd2;
      default: occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage : pipeline_pkg

// File: rtl/pipe_skid_stage.sv
// Elastic inter-stage pipeline register with a 2-entry skid buffer.
// Valid/ready on both sides; all outputs decode registered state only, so
// there is no combinational path from any input to any output.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        asynchronous active-high reset
//   flush_i      kill every held entry (synchronous, highest priority)
//   valid_i      upstream beat present on data_i
//   ready_o      stage can accept a beat this cycle
//   data_i       upstream payload
//   valid_o      data_o holds a live beat
//   ready_i      downstream accepts data_o this cycle
//   data_o       payload to downstream (main register)
//   occupancy_o  held beats, 0..2
//   stall_cnt_o  saturating count of cycles with valid_o=1 and ready_i=0
module pipe_skid_stage
  import pipeline_pkg::*;
#(
  parameter int unsigned DATA_W         = 64,
  parameter bit          CLEAR_ON_FLUSH = 1'b1,
  parameter int unsigned CNT_W          = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] data_o,
  output logic [1:0]        occupancy_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  skid_state_e       state_q, state_d;
  logic [DATA_W-1:0] main_q,  main_d;
  logic [DATA_W-1:0] skid_q,  skid_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic in_fire_c;
  logic out_fire_c;
  logic stall_c;

  // Output decode from registered state.
  assign ready_o     = (state_q != FULL);
  assign valid_o     = (state_q != EMPTY);
  assign data_o      = main_q;
  assign occupancy_o = skid_occupancy(state_q);
  assign stall_cnt_o = stall_cnt_q;

  // Handshake qualifiers.
  assign in_fire_c  = valid_i & ready_o;
  assign out_fire_c = valid_o & ready_i;
  assign stall_c    = valid_o & ~ready_i;

  // Next-state and datapath: main always holds the oldest beat, skid the younger.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    if (flush_i) begin
      // Offered beat is dropped; an out_fire this cycle is still delivered.
      state_d = EMPTY;
      if (CLEAR_ON_FLUSH) begin
        main_d = '0;
        skid_d = '0;
      end
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire_c) begin
            main_d  = data_i;
            state_d = BUSY;
          end
        end
        BUSY: begin
          if (in_fire_c && out_fire_c) begin
            main_d = data_i;
          end else if (in_fire_c) begin
            skid_d  = data_i;
            state_d = FULL;
          end else if (out_fire_c) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          // ready_o is low here, so only the drain side can move.
          if (out_fire_c) begin
            main_d  = skid_q;
            state_d = BUSY;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  // Back-pressure counter, saturating; flush does not clear it.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_c && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // State and data registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule : pipe_skid_stage

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: two instances (clear-on-flush and hold-on-flush)
// share stimulus and are checked every cycle against a queue-based model.
module tb_pipe_skid_stage;

  localparam int unsigned DW  = 8;
  localparam int unsigned CW  = 4;
  localparam int          CNT_SAT = 15;

  logic          clk;
  logic          rst;
  logic          flush_i;
  logic          valid_i;
  logic [DW-1:0] data_i;
  logic          ready_i;

  logic          c_ready, c_valid, h_ready, h_valid;
  logic [DW-1:0] c_data, h_data;
  logic [1:0]    c_occ, h_occ;
  logic [CW-1:0] c_cnt, h_cnt;

  pipe_skid_stage #(.DATA_W(DW), .CLEAR_ON_FLUSH(1'b1), .CNT_W(CW)) u_dut_clr (
    .clk_i(clk), .rst_i(rst), .flush_i(flush_i),
    .valid_i(valid_i), .ready_o(c_ready), .data_i(data_i),
    .valid_o(c_valid), .ready_i(ready_i), .data_o(c_data),
    .occupancy_o(c_occ), .stall_cnt_o(c_cnt)
  );

  pipe_skid_stage #(.DATA_W(DW), .CLEAR_ON_FLUSH(1'b0), .CNT_W(CW)) u_dut_hold (
    .clk_i(clk), .rst_i(rst), .flush_i(flush_i),
    .valid_i(valid_i), .ready_o(h_ready), .data_i(data_i),
    .valid_o(h_valid), .ready_i(ready_i), .data_o(h_data),
    .occupancy_o(h_occ), .stall_cnt_o(h_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: FIFO of held beats (at most two), last presented value
  // per instance, and the stall count.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_main_clr;
  logic [DW-1:0] m_main_hold;
  int            m_cnt;

  // Scoreboard of beats actually exchanged with the clear-on-flush instance.
  logic [DW-1:0] sent[$];
  logic [DW-1:0] rcvd[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_main_clr  = '0;
    m_main_hold = '0;
    m_cnt       = 0;
  endtask

  task automatic check_outputs();
    int sz;
    sz = mq.size();
    chk("clr_valid", 32'(c_valid), 32'(sz > 0));
    chk("clr_ready", 32'(c_ready), 32'(sz < 2));
    chk("clr_occ",   32'(c_occ),   32'(sz));
    chk("clr_data",  32'(c_data),  32'(m_main_clr));
    chk("clr_cnt",   32'(c_cnt),   32'(m_cnt));
    chk("hold_valid", 32'(h_valid), 32'(sz > 0));
    chk("hold_ready", 32'(h_ready), 32'(sz < 2));
    chk("hold_occ",   32'(h_occ),   32'(sz));
    chk("hold_data",  32'(h_data),  32'(m_main_hold));
    chk("hold_cnt",   32'(h_cnt),   32'(m_cnt));
  endtask

  // One clock: drive inputs, advance the model, check both instances.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic r, input logic f);
    logic in_f, out_f;
    valid_i = v;
    data_i  = d;
    ready_i = r;
    flush_i = f;
    in_f  = v && (mq.size() < 2);
    out_f = (mq.size() > 0) && r;
    if (c_valid && ready_i) rcvd.push_back(c_data);
    if (valid_i && c_ready && !f) sent.push_back(data_i);
    if ((mq.size() > 0) && !r && (m_cnt < CNT_SAT)) m_cnt++;
    @(posedge clk);
    #1;
    if (f) begin
      mq.delete();
      m_main_clr = '0;
    end else begin
      if (out_f) void'(mq.pop_front());
      if (in_f) mq.push_back(d);
      if (mq.size() > 0) begin
        m_main_clr  = mq[0];
        m_main_hold = mq[0];
      end
    end
    check_outputs();
  endtask

  initial begin
    logic [DW-1:0] held_main;
    logic          hv;
    logic [DW-1:0] hd;
    logic          r;
    logic          acc;
    int            cyc;

    rst = 1'b1; flush_i = 1'b0; valid_i = 1'b0; data_i = '0; ready_i = 1'b0;
    model_reset();
    #12;
    check_outputs();
    @(posedge clk); #1 rst = 1'b0;

    // Streaming at full rate.
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, DW'(i), 1'b1, 1'b0);
      chk("stream_data", 32'(c_data), 32'(i));
      chk("stream_occ",  32'(c_occ),  32'd1);
    end
    step(1'b0, '0, 1'b1, 1'b0);
    chk("stream_drain", 32'(c_valid), 32'd0);

    // Back-pressure fills main then skid; third beat is held off.
    step(1'b1, 8'hA1, 1'b0, 1'b0);
    step(1'b1, 8'hA2, 1'b0, 1'b0);
    chk("bp_ready", 32'(c_ready), 32'd0);
    chk("bp_occ",   32'(c_occ),   32'd2);
    step(1'b1, 8'hA3, 1'b0, 1'b0);
    chk("bp_main",  32'(c_data),  32'hA1);
    step(1'b1, 8'hA3, 1'b1, 1'b0);
    chk("bp_out2",  32'(c_data),  32'hA2);
    step(1'b1, 8'hA3, 1'b1, 1'b0);
    chk("bp_out3",  32'(c_data),  32'hA3);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("bp_empty", 32'(c_occ),   32'd0);

    // Flush while FULL with a beat offered.
    step(1'b1, 8'h61, 1'b0, 1'b0);
    step(1'b1, 8'h62, 1'b0, 1'b0);
    held_main = h_data;
    step(1'b1, 8'h55, 1'b0, 1'b1);
    chk("flush_valid",  32'(c_valid), 32'd0);
    chk("flush_ready",  32'(c_ready), 32'd1);
    chk("flush_occ",    32'(c_occ),   32'd0);
    chk("flush_clr",    32'(c_data),  32'h00);
    chk("flush_hold",   32'(h_data),  32'(held_main));
    chk("flush_hvalid", 32'(h_valid), 32'd0);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("flush_no55",   32'(c_data == 8'h55), 32'd0);

    // Asynchronous reset in the middle of a FULL cycle.
    step(1'b1, 8'h11, 1'b0, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b0);
    chk("pre_rst_occ", 32'(c_occ), 32'd2);
    valid_i = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_valid", 32'(c_valid), 32'd0);
    chk("rst_ready", 32'(c_ready), 32'd1);
    chk("rst_occ",   32'(c_occ),   32'd0);
    chk("rst_data",  32'(c_data),  32'h00);
    chk("rst_cnt",   32'(c_cnt),   32'd0);
    model_reset();
    @(posedge clk); #1 rst = 1'b0;

    // Stall counter saturation.
    step(1'b1, 8'h5A, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b0, 1'b0);
    chk("sat_cnt", 32'(c_cnt), 32'd15);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("sat_hold", 32'(c_cnt), 32'd15);

    // Random traffic; the source holds an offered beat until accepted.
    sent.delete();
    rcvd.delete();
    hv = 1'b0; hd = '0; cyc = 0;
    while ((sent.size() < 1000) && (cyc < 20000)) begin
      if (!hv) begin
        hv = 1'($urandom_range(0, 1));
        hd = DW'($urandom);
      end
      r   = 1'($urandom_range(0, 1));
      acc = hv && c_ready;
      step(hv, hd, r, 1'b0);
      if (c_occ == 2'd2) chk("rand_full_ready", 32'(c_ready), 32'd0);
      if (acc) hv = 1'b0;
      cyc++;
    end
    chk("rand_budget", 32'(sent.size() >= 1000), 32'd1);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0);
    chk("rand_count", 32'(rcvd.size()), 32'(sent.size()));
    for (int i = 0; i < sent.size() && i < rcvd.size(); i++) begin
      chk("rand_order", 32'(rcvd[i]), 32'(sent[i]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_pipe_skid_stage
